// File: rtl/imem_pkg.sv
// Shared types and constants for the multi-cycle instruction-memory responder.
// Holds the responder FSM encoding, default geometry/latency and the NOP word
// returned whenever no valid completion is being presented.
package imem_pkg;

  localparam int ADDR_W_DEFAULT  = 16;
  localparam int LATENCY_DEFAULT = 4;

  // Latency counter width; covers the legal LATENCY range 1..15.
  localparam int CNT_W = 4;

  // Word driven on rsp_data outside the completion cycle and on error.
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/imem_word_array.sv
// Word-addressed instruction store: synchronous write, asynchronous read.
// No reset, so contents survive a responder reset and boot preloads are kept.
// Read data reflects writes only after the write clock edge.
module imem_word_array #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Preload port: write lands at the clock edge, in any responder state.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_stall_responder.sv
// Responder end of the fetch instruction-memory port: accepts a word read,
// stalls fetch for LATENCY-1 cycles, then pulses rsp_done with the word.
// Optional feature macro IMEM_ALIGN_ERR_EN: odd request addresses complete
// with rsp_err=1 and a NOP data word instead of reading the containing word.
module imem_stall_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [15:0] req_addr,
  output logic [15:0] rsp_data,
  output logic        rsp_done,
  output logic        rsp_stall,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        rsp_err
);

  localparam int IW = ADDR_W - 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    idx_q;
  logic             done_q;
  logic             stall_q;
  logic             err_q;
  logic [15:0]      rd_word;
  logic             accept;

  // Byte bit 0 and any address bits above ADDR_W take no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr, ld_addr};

  // Requests are only taken when nothing is in flight (IDLE or DONE).
  assign accept = req_en && !stall_q;

  imem_word_array #(
    .AW (IW),
    .DW (16)
  ) u_store (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr[ADDR_W-1:1]),
    .wdata (ld_data),
    .raddr (idx_q),
    .rdata (rd_word)
  );

  // Responder FSM: address latch, latency countdown and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            idx_q <= req_addr[ADDR_W-1:1];
`ifdef IMEM_ALIGN_ERR_EN
            err_q <= req_addr[0];
`else
            err_q <= 1'b0;
`endif
            cnt   <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state   <= DONE;
              done_q  <= 1'b1;
              stall_q <= 1'b0;
            end else begin
              state   <= BUSY;
              done_q  <= 1'b0;
              stall_q <= 1'b1;
            end
          end else begin
            state   <= IDLE;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state   <= DONE;
            done_q  <= 1'b1;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_done  = done_q;
  assign rsp_stall = stall_q;

  // The store is read during the DONE cycle itself, so BUSY-time preloads of the
  // in-flight word are returned while a DONE-cycle write is not yet visible.
`ifdef IMEM_ALIGN_ERR_EN
  assign rsp_err  = done_q && err_q;
  assign rsp_data = (done_q && !err_q) ? rd_word : NOP_WORD;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign rsp_err  = 1'b0;
  assign rsp_data = done_q ? rd_word : NOP_WORD;
`endif

endmodule

// File: tb/tb_imem_stall_responder.sv
// Directed bench for imem_stall_responder with default ADDR_W=16, LATENCY=4.
// Inputs are driven and outputs sampled 1ns after the rising edge.
// Alignment expectations follow whether IMEM_ALIGN_ERR_EN is defined.
module tb_imem_stall_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic [15:0] req_addr;
  logic [15:0] rsp_data;
  logic        rsp_done;
  logic        rsp_stall;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_stall_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_en    (req_en),
    .req_addr  (req_addr),
    .rsp_data  (rsp_data),
    .rsp_done  (rsp_done),
    .rsp_stall (rsp_stall),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rsp_err   (rsp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // Drives req_en for one cycle; returns positioned in cycle N+1.
  task automatic issue(input logic [15:0] a);
    req_en   = 1'b1;
    req_addr = a;
    step();
    req_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_en = 1'b0; req_addr = 16'h0;
    ld_en = 1'b1; ld_addr = 16'h0020; ld_data = 16'hBEEF;
    step();
    ld_en = 1'b0;
    step();
    checks++;
    if (rsp_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rsp_done); end
    checks++;
    if (rsp_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", rsp_stall); end
    checks++;
    if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", rsp_data); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (rsp_done !== 1'b0 || rsp_stall !== 1'b0 || rsp_data !== 16'h0000) begin
        errors++;
        $display("FAIL idle_quiet cyc%0d got done=%b stall=%b data=%h want 0/0/0000", k, rsp_done, rsp_stall, rsp_data);
      end
    end
  endtask

  task automatic test_single();
    load(16'h0010, 16'hA5C3);
    issue(16'h0010);
    // cycles N+1..N+3: stalled; a request raised at N+2 must be ignored
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin req_en = 1'b1; req_addr = 16'h0020; end
      else        begin req_en = 1'b0; req_addr = 16'hFFFE; end
      checks++;
      if (rsp_stall !== 1'b1 || rsp_done !== 1'b0 || rsp_data !== 16'h0000) begin
        errors++;
        $display("FAIL single_busy N+%0d got stall=%b done=%b data=%h want 1/0/0000", k, rsp_stall, rsp_done, rsp_data);
      end
      step();
    end
    req_en = 1'b0;
    checks++;
    if (rsp_done !== 1'b1 || rsp_stall !== 1'b0 || rsp_data !== 16'hA5C3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_done got done=%b stall=%b data=%h err=%b want 1/0/a5c3/0", rsp_done, rsp_stall, rsp_data, rsp_err);
    end
    step();
    checks++;
    if (rsp_done !== 1'b0 || rsp_stall !== 1'b0 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL single_after got done=%b stall=%b data=%h want 0/0/0000", rsp_done, rsp_stall, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_done;
    logic [15:0] exp_data;
    load(16'h0000, 16'h1111);
    load(16'h0002, 16'h2222);
    req_en = 1'b1; req_addr = 16'h0000;
    step();
    req_addr = 16'h0002;
    for (int k = 1; k <= 8; k++) begin
      exp_done = (k == 4) || (k == 8);
      exp_data = (k == 4) ? 16'h1111 : (k == 8) ? 16'h2222 : 16'h0000;
      if (k == 8) req_en = 1'b0;
      checks++;
      if (rsp_done !== exp_done || rsp_stall !== !exp_done || rsp_data !== exp_data) begin
        errors++;
        $display("FAIL b2b N+%0d got done=%b stall=%b data=%h want %b/%b/%h", k, rsp_done, rsp_stall, rsp_data, exp_done, !exp_done, exp_data);
      end
      step();
    end
    checks++;
    if (rsp_done !== 1'b0 || rsp_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got done=%b stall=%b want 0/0", rsp_done, rsp_stall);
    end
  endtask

  task automatic test_busy_write();
    load(16'h0030, 16'h0BAD);
    issue(16'h0030);
    step();
    step();
    // last BUSY cycle (N+3): write lands before the DONE-cycle read
    ld_en = 1'b1; ld_addr = 16'h0030; ld_data = 16'h1234;
    step();
    ld_en = 1'b0;
    checks++;
    if (rsp_done !== 1'b1 || rsp_data !== 16'h1234) begin
      errors++;
      $display("FAIL busy_write got done=%b data=%h want 1/1234", rsp_done, rsp_data);
    end
    step();
  endtask

  task automatic test_done_write();
    load(16'h0040, 16'h4444);
    issue(16'h0040);
    step(); step(); step();
    ld_en = 1'b1; ld_addr = 16'h0040; ld_data = 16'h9999;
    #1;
    checks++;
    if (rsp_done !== 1'b1 || rsp_data !== 16'h4444) begin
      errors++;
      $display("FAIL done_write_old got done=%b data=%h want 1/4444", rsp_done, rsp_data);
    end
    step();
    ld_en = 1'b0;
    issue(16'h0040);
    step(); step(); step();
    checks++;
    if (rsp_done !== 1'b1 || rsp_data !== 16'h9999) begin
      errors++;
      $display("FAIL done_write_new got done=%b data=%h want 1/9999", rsp_done, rsp_data);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    issue(16'h0010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rsp_done !== 1'b0 || rsp_stall !== 1'b0 || rsp_data !== 16'h0000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_N3 got done=%b stall=%b data=%h err=%b want 0/0/0000/0", rsp_done, rsp_stall, rsp_data, rsp_err);
    end
    for (int k = 4; k <= 6; k++) begin
      step();
      checks++;
      if (rsp_done !== 1'b0 || rsp_stall !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_N%0d got done=%b stall=%b want 0/0", k, rsp_done, rsp_stall);
      end
    end
  endtask

  task automatic test_ld_during_reset();
    issue(16'h0020);
    step(); step(); step();
    checks++;
    if (rsp_done !== 1'b1 || rsp_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL ld_in_reset got done=%b data=%h want 1/beef", rsp_done, rsp_data);
    end
    step();
  endtask

  task automatic test_align();
    issue(16'h0011);
    step(); step(); step();
`ifdef IMEM_ALIGN_ERR_EN
    checks++;
    if (rsp_done !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL align_odd got done=%b err=%b data=%h want 1/1/0000", rsp_done, rsp_err, rsp_data);
    end
`else
    checks++;
    if (rsp_done !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 16'hA5C3) begin
      errors++;
      $display("FAIL align_odd got done=%b err=%b data=%h want 1/0/a5c3", rsp_done, rsp_err, rsp_data);
    end
`endif
    step();
    checks++;
    if (rsp_err !== 1'b0 || rsp_done !== 1'b0) begin
      errors++;
      $display("FAIL align_after got done=%b err=%b want 0/0", rsp_done, rsp_err);
    end
  endtask

  initial begin
    rst = 1'b1; req_en = 1'b0; req_addr = 16'h0;
    ld_en = 1'b0; ld_addr = 16'h0; ld_data = 16'h0;
    #1;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_busy_write();
    test_done_write();
    test_reset_midflight();
    test_ld_during_reset();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
